// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the IF/MEM byte-RAM arbiter.
//   - state_e     : arbiter FSM states
//   - Len*        : mem_len encodings (3 is treated as a word)
//   - len_to_n()  : mem_len -> byte count N (1/2/4)
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned InstAddrBus = 32;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [1:0] LenByte    = 2'd0;
    localparam logic [1:0] LenHalf    = 2'd1;
    localparam logic [1:0] LenWord    = 2'd2;
    localparam logic [1:0] LenWordAlt = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIfRd,
        StMemRd,
        StMemWr
    } state_e;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            LenByte: return 3'd1;
            LenHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the IF request port, the MEM request port and the byte RAM port.
//   slave  : arbiter view (requests and ram_din in; done/data/ram_* out)
//   master : requester + RAM view (the opposite directions)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arbiter_pkg::InstAddrBus
);
    logic              branch_interception;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  branch_interception, if_req, if_addr,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output ram_a, ram_wr, ram_dout
    );

    modport master (
        output branch_interception, if_req, if_addr,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  ram_a, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_arbiter_byte_seq.sv
// ---------------------------------------------------------------------------
// mem_arbiter_byte_seq
// Byte counter, serialiser and little-endian assembler for one access.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : start a new access (latches base/len/wdata, cnt=0)
//   i_run        : access in progress, advance cnt every edge
//   i_base       : byte base address
//   i_len_n      : byte count N (1/2/4)
//   i_wdata      : store data, byte 0 = bits 7:0
//   i_ram_din    : RAM read byte (for address presented last cycle)
//   o_addr       : base + cnt (wraps modulo 2^ADDR_W)
//   o_wbyte      : store byte cnt
//   o_in_range   : cnt < N
//   o_rd_last    : cnt == N (last read byte arrives this cycle)
//   o_wr_last    : cnt == N-1 (last store byte on the bus this cycle)
//   o_word       : assembled word including this cycle's ram_din
// ---------------------------------------------------------------------------
module mem_arbiter_byte_seq #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_run,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [2:0]        i_len_n,
    input  logic [31:0]       i_wdata,
    input  logic [7:0]        i_ram_din,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wbyte,
    output logic              o_in_range,
    output logic              o_rd_last,
    output logic              o_wr_last,
    output logic [31:0]       o_word
);
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len_n;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [2:0]        w_prev;

    assign w_prev     = r_cnt - 3'd1;
    assign o_addr     = r_base + ADDR_W'(r_cnt);
    assign o_wbyte    = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    assign o_in_range = (r_cnt < r_len_n);
    assign o_rd_last  = (r_cnt == r_len_n);
    assign o_wr_last  = (r_cnt == (r_len_n - 3'd1));

    // RAM data lags the address by one cycle, so at cnt the byte on
    // ram_din belongs to offset cnt-1.
    always_comb begin
        o_word = r_asm;
        if (r_cnt != 3'd0) begin
            o_word[{w_prev[1:0], 3'b000} +: 8] = i_ram_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 3'd0;
            r_base  <= '0;
            r_len_n <= 3'd0;
            r_wdata <= 32'd0;
            r_asm   <= 32'd0;
        end else if (i_load) begin
            r_cnt   <= 3'd0;
            r_base  <= i_base;
            r_len_n <= i_len_n;
            r_wdata <= i_wdata;
            r_asm   <= 32'd0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 3'd1;
            r_asm <= o_word;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-wide RAM port between instruction fetch and load/store.
// Multi-byte requests are serialised into ascending byte accesses; read
// data is assembled little-endian and returned with a one-cycle done pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave
//              IF  : if_req/if_addr in, if_done/if_data out,
//                    branch_interception cancels/refuses fetches
//              MEM : mem_req/we/len/addr/wdata in, mem_done/mem_rdata out
//              RAM : ram_a/ram_wr/ram_dout out, ram_din in (1-cycle latency)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_e            r_state;
    state_e            w_state_d;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_data;
    logic [31:0]       r_mem_rdata;

    logic              w_load_if;
    logic              w_load_mem;
    logic              w_if_fin;
    logic              w_mem_fin;
    logic [ADDR_W-1:0] w_base;
    logic [2:0]        w_len_n;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_wbyte;
    logic              w_in_range;
    logic              w_rd_last;
    logic              w_wr_last;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_ram_a;
    logic              w_ram_wr;
    logic [7:0]        w_ram_dout;

    assign w_base  = w_load_mem ? bus.mem_addr : bus.if_addr;
    assign w_len_n = w_load_mem ? len_to_n(bus.mem_len) : 3'd4;

    mem_arbiter_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_byte_seq (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load_if | w_load_mem),
        .i_run      (r_state != StIdle),
        .i_base     (w_base),
        .i_len_n    (w_len_n),
        .i_wdata    (bus.mem_wdata),
        .i_ram_din  (bus.ram_din),
        .o_addr     (w_addr),
        .o_wbyte    (w_wbyte),
        .o_in_range (w_in_range),
        .o_rd_last  (w_rd_last),
        .o_wr_last  (w_wr_last),
        .o_word     (w_word)
    );

    // Next state. A port whose done is high this cycle is masked so the
    // still-asserted request is not taken as a new one.
    always_comb begin
        w_state_d  = r_state;
        w_load_if  = False;
        w_load_mem = False;
        w_if_fin   = False;
        w_mem_fin  = False;
        unique case (r_state)
            StIdle: begin
                if (bus.mem_req && !r_mem_done) begin
                    w_load_mem = True;
                    w_state_d  = bus.mem_we ? StMemWr : StMemRd;
                end else if (bus.if_req && !r_if_done && !bus.branch_interception) begin
                    w_load_if = True;
                    w_state_d = StIfRd;
                end
            end
            StIfRd: begin
                // Flush wins over completion: the fetched word is dropped.
                if (bus.branch_interception) begin
                    w_state_d = StIdle;
                end else if (w_rd_last) begin
                    w_state_d = StIdle;
                    w_if_fin  = True;
                end
            end
            StMemRd: begin
                if (w_rd_last) begin
                    w_state_d = StIdle;
                    w_mem_fin = True;
                end
            end
            StMemWr: begin
                if (w_wr_last) begin
                    w_state_d = StIdle;
                    w_mem_fin = True;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // RAM port is Moore: driven only from registered state.
    always_comb begin
        w_ram_a    = '0;
        w_ram_wr   = False;
        w_ram_dout = 8'd0;
        unique case (r_state)
            StIfRd, StMemRd: begin
                if (w_in_range) begin
                    w_ram_a = w_addr;
                end
            end
            StMemWr: begin
                w_ram_wr   = True;
                w_ram_a    = w_addr;
                w_ram_dout = w_wbyte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_if_done   <= False;
            r_mem_done  <= False;
            r_if_data   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_state    <= w_state_d;
            r_if_done  <= w_if_fin;
            r_mem_done <= w_mem_fin;
            if (w_load_if) begin
                r_if_data <= 32'd0;
            end else if (w_if_fin) begin
                r_if_data <= w_word;
            end
            if (w_load_mem) begin
                r_mem_rdata <= 32'd0;
            end else if (w_mem_fin && (r_state == StMemRd)) begin
                r_mem_rdata <= w_word;
            end
        end
    end

    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.ram_a     = w_ram_a;
    assign bus.ram_wr    = w_ram_wr;
    assign bus.ram_dout  = w_ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a table of MEM transactions plus
// hand-written sequences for fetch, stale request, contention, flush and
// reset in the middle of a store. Expected read data is pushed to per-port
// queues when a request is driven and popped when the done pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW)) bus ();

    mem_arbiter #(
        .ADDR_W (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte RAM model: 4 KiB mirror indexed by the low address bits,
    // read data valid one cycle after the address.
    logic [7:0]  ram [0:4095];
    logic        mem_clr;
    logic        pl_we;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (bus.ram_wr) begin
            ram[bus.ram_a[11:0]] <= bus.ram_dout;
        end
        bus.ram_din <= ram[bus.ram_a[11:0]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        chk_data;
        logic [31:0] data;
    } sb_t;

    sb_t mem_q[$];
    sb_t if_q[$];
    sb_t mon_mem_e;
    sb_t mon_if_e;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_done === 1'b1) begin
            check("mem_done_expected", 32'(mem_q.size() != 0), 32'd1);
            if (mem_q.size() != 0) begin
                mon_mem_e = mem_q.pop_front();
                if (mon_mem_e.chk_data) begin
                    check({mon_mem_e.name, "_rdata"}, bus.mem_rdata, mon_mem_e.data);
                end
            end
        end
        if (bus.if_done === 1'b1) begin
            check("if_done_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
                mon_if_e = if_q.pop_front();
                check({mon_if_e.name, "_if_data"}, bus.if_data, mon_if_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Waits (bounded) for a done pulse, then checks the cycle count.
    task automatic wait_done(input logic is_if, input int exp_lat, input string name);
        int j;
        j = 0;
        while (((is_if ? bus.if_done : bus.mem_done) !== 1'b1) && j < 20) begin
            tick();
            j++;
        end
        check({name, "_lat"}, 32'(j), 32'(exp_lat));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_if_done"}, 32'(bus.if_done), 32'd0);
        check({name, "_mem_done"}, 32'(bus.mem_done), 32'd0);
        check({name, "_ram_wr"}, 32'(bus.ram_wr), 32'd0);
        check({name, "_ram_a"}, bus.ram_a, 32'd0);
        check({name, "_ram_dout"}, 32'(bus.ram_dout), 32'd0);
        check({name, "_if_data"}, bus.if_data, 32'd0);
        check({name, "_mem_rdata"}, bus.mem_rdata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic run_mem(input vec_t v, input string name);
        int          n;
        int          j;
        logic [31:0] e_a;
        logic [31:0] sh;
        sb_t         e;
        n = (v.len == LenByte) ? 1 : (v.len == LenHalf) ? 2 : 4;
        e.name     = name;
        e.chk_data = !v.we;
        e.data     = v.exp_rdata;
        mem_q.push_back(e);
        bus.mem_req   = 1'b1;
        bus.mem_we    = v.we;
        bus.mem_len   = v.len;
        bus.mem_addr  = v.addr;
        bus.mem_wdata = v.wdata;
        tick();
        j = 0;
        while (bus.mem_done !== 1'b1 && j < 20) begin
            if (j < n) begin
                e_a = v.addr + 32'(j);
                sh  = v.wdata >> (8 * j);
                check($sformatf("%s_b%0d_ram_a", name, j), bus.ram_a, e_a);
                check($sformatf("%s_b%0d_ram_wr", name, j), 32'(bus.ram_wr), 32'(v.we));
                if (v.we) begin
                    check($sformatf("%s_b%0d_dout", name, j), 32'(bus.ram_dout), 32'(sh[7:0]));
                end
            end
            tick();
            j++;
        end
        check({name, "_lat"}, 32'(j), 32'(v.exp_lat));
        bus.mem_req = 1'b0;
        tick();
    endtask

    task automatic run_if(input logic [31:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        e.name     = name;
        e.chk_data = 1'b1;
        e.data     = exp;
        if_q.push_back(e);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        tick();
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_b%0d_ram_a", name, j), bus.ram_a, addr + 32'(j));
            tick();
        end
        wait_done(1'b1, 1, name);
        bus.if_req = 1'b0;
        tick();
    endtask

    vec_t vecs[11];
    sb_t  e;
    logic seen;

    initial begin
        vecs[0]  = '{1'b1, LenHalf,    32'h0000_0200, 32'h0000_BEEF, 32'h0,          2};
        vecs[1]  = '{1'b0, LenWord,    32'h0000_0200, 32'h0,         32'h0000_BEEF, 5};
        vecs[2]  = '{1'b1, LenWord,    32'h0000_0200, 32'hDEAD_BEEF, 32'h0,          4};
        vecs[3]  = '{1'b0, LenWord,    32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 5};
        vecs[4]  = '{1'b0, LenHalf,    32'h0000_0201, 32'h0,         32'h0000_ADBE, 3};
        vecs[5]  = '{1'b0, LenByte,    32'h0000_0203, 32'h0,         32'h0000_00DE, 2};
        vecs[6]  = '{1'b1, LenHalf,    32'h0000_0210, 32'h1234_5678, 32'h0,          2};
        vecs[7]  = '{1'b1, LenByte,    32'h0000_0213, 32'h1234_56AA, 32'h0,          1};
        vecs[8]  = '{1'b0, LenWordAlt, 32'h0000_0210, 32'h0,         32'hAA00_5678, 5};
        vecs[9]  = '{1'b1, LenWord,    32'hFFFF_FFFE, 32'h1122_3344, 32'h0,          4};
        vecs[10] = '{1'b0, LenWord,    32'hFFFF_FFFF, 32'h0,         32'h0011_2233, 5};

        rst                     = 1'b1;
        mem_clr                 = 1'b1;
        pl_we                   = 1'b0;
        pl_a                    = 12'd0;
        pl_d                    = 8'd0;
        bus.branch_interception = 1'b0;
        bus.if_req              = 1'b0;
        bus.if_addr             = '0;
        bus.mem_req             = 1'b0;
        bus.mem_we              = 1'b0;
        bus.mem_len             = 2'd0;
        bus.mem_addr            = '0;
        bus.mem_wdata           = 32'd0;
        tick();
        mem_clr = 1'b0;
        preload(12'h100, 8'h13);
        preload(12'h101, 8'h05);
        preload(12'h102, 8'hA0);
        preload(12'h103, 8'h00);
        preload(12'h300, 8'h7F);
        preload(12'h040, 8'h93);
        preload(12'h041, 8'h00);
        preload(12'h042, 8'h10);
        preload(12'h043, 8'h00);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();
        check_idle_outputs("idle");

        // Word fetch.
        run_if(32'h0000_0100, 32'h00A0_0513, "fetch");

        // Stale request: if_req held through the if_done cycle.
        e = '{"stale1", 1'b1, 32'h00A0_0513};
        if_q.push_back(e);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        wait_done(1'b1, 6, "stale1");
        tick();
        check("stale_no_accept_ram_a", bus.ram_a, 32'd0);
        tick();
        check("stale_accept_ram_a", bus.ram_a, 32'h0000_0100);
        e = '{"stale2", 1'b1, 32'h00A0_0513};
        if_q.push_back(e);
        wait_done(1'b1, 5, "stale2");
        bus.if_req = 1'b0;
        tick();

        // Table of MEM transactions.
        for (int i = 0; i < 11; i++) begin
            run_mem(vecs[i], $sformatf("vec%0d", i));
        end

        // Contention: MEM first, IF right after mem_done.
        e = '{"cont_ld", 1'b1, 32'h0000_007F};
        mem_q.push_back(e);
        e = '{"cont_if", 1'b1, 32'h00A0_0513};
        if_q.push_back(e);
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0100;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b0;
        bus.mem_len  = LenByte;
        bus.mem_addr = 32'h0000_0300;
        tick();
        check("cont_mem_first_ram_a", bus.ram_a, 32'h0000_0300);
        wait_done(1'b0, 2, "cont_mem");
        bus.mem_req = 1'b0;
        check("cont_no_overlap_ram_a", bus.ram_a, 32'd0);
        tick();
        check("cont_if_accept_ram_a", bus.ram_a, 32'h0000_0100);
        wait_done(1'b1, 5, "cont_if");
        bus.if_req = 1'b0;
        tick();

        // Flush two cycles into a fetch, then refuse while still flushing.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        tick();
        tick();
        bus.branch_interception = 1'b1;
        tick();
        check("flush_idle_ram_a", bus.ram_a, 32'd0);
        check("flush_ram_wr", 32'(bus.ram_wr), 32'd0);
        tick();
        check("flush_refuse_ram_a", bus.ram_a, 32'd0);
        bus.branch_interception = 1'b0;
        bus.if_req              = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.if_done === 1'b1) seen = 1'b1;
            tick();
        end
        check("flush_no_if_done", 32'(seen), 32'd0);
        run_if(32'h0000_0040, 32'h0010_0093, "fetch40");

        // Reset during byte 1 of a 4-byte store.
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_len   = LenWord;
        bus.mem_addr  = 32'h0000_0220;
        bus.mem_wdata = 32'hCAFE_F00D;
        tick();
        tick();
        check("rststore_b1_ram_a", bus.ram_a, 32'h0000_0221);
        rst         = 1'b1;
        bus.mem_req = 1'b0;
        tick();
        check_idle_outputs("rststore");
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.mem_done === 1'b1) seen = 1'b1;
            tick();
        end
        check("rststore_no_mem_done", 32'(seen), 32'd0);
        check("rststore_byte2_untouched", 32'(ram[12'h222]), 32'd0);

        check("sb_mem_empty", 32'(mem_q.size()), 32'd0);
        check("sb_if_empty", 32'(if_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
